// File: rtl/idct_row_pkg.sv
// Shared types and constants for the 8-point row IDCT: the port record,
// the row length, the fixed-point shift and the cosine coefficient table.
package idct_row_pkg;

    localparam int ROW_LEN      = 8;
    localparam int COEF_SHIFT   = 11;
    localparam int DCT_IN_WIDTH = 14;

    typedef struct packed {
        logic signed [DCT_IN_WIDTH-1:0] data;
        logic                           valid;
    } dctPort_t;

    // W[n][k] = round(2048 * C(k)/2 * cos((2n+1)k*pi/16)); row n is one output sample
    localparam int W [ROW_LEN][ROW_LEN] = '{
        '{724,  1004,  946,   851,  724,   569,  392,   200},
        '{724,   851,  392,  -200, -724, -1004, -946,  -569},
        '{724,   569, -392, -1004, -724,   200,  946,   851},
        '{724,   200, -946,  -569,  724,   851, -392, -1004},
        '{724,  -200, -946,   569,  724,  -851, -392,  1004},
        '{724,  -569, -392,  1004, -724,  -200,  946,  -851},
        '{724,  -851,  392,   200, -724,  1004, -946,   569},
        '{724, -1004,  946,  -851,  724,  -569,  392,  -200}
    };

endpackage

// File: rtl/idct_row_mac8.sv
// Eight parallel multiply-accumulators, one per output sample, with the
// round-half-up shift and saturation applied to the final running sum.
module idct_mac8
    import idct_row_pkg::*;
#(
    parameter int IN_WIDTH   = 14,
    parameter int OUT_WIDTH  = 10,
    parameter int COEF_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        en_i,
    input  logic                        first_i,
    input  logic [2:0]                  k_i,
    input  logic signed [IN_WIDTH-1:0]  x_i,
    output logic signed [OUT_WIDTH-1:0] result_o [ROW_LEN]
);

    localparam int ACC_W = IN_WIDTH + COEF_WIDTH + 3;
    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(1 << (COEF_SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_WIDTH - 1)));

    logic signed [ACC_W-1:0]      acc_q   [ROW_LEN];
    logic signed [ACC_W-1:0]      acc_d   [ROW_LEN];
    logic signed [ACC_W-1:0]      rounded [ROW_LEN];
    logic signed [COEF_WIDTH-1:0] coef    [ROW_LEN];
    logic signed [ACC_W-1:0]      xExt;

    assign xExt = ACC_W'(x_i);

    // result_o reflects the sum including this cycle's term, so the top can
    // capture it on the same edge the last term is accumulated
    always_comb begin
        for (int n = 0; n < ROW_LEN; n++) begin
            coef[n]    = COEF_WIDTH'(W[n][k_i]);
            acc_d[n]   = (first_i ? ACC_W'(0) : acc_q[n]) + xExt * ACC_W'(coef[n]);
            rounded[n] = (acc_d[n] + ROUND_C) >>> COEF_SHIFT;
            if (rounded[n] > SAT_MAX) begin
                result_o[n] = OUT_WIDTH'(SAT_MAX);
            end else if (rounded[n] < SAT_MIN) begin
                result_o[n] = OUT_WIDTH'(SAT_MIN);
            end else begin
                result_o[n] = OUT_WIDTH'(rounded[n]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/idct_row.sv
// Row IDCT pipeline: capture eight coefficients, run eight MAC cycles on the
// previous row, then stream eight samples out; all three stages overlap.
module idct_row
    import idct_row_pkg::*;
#(
    parameter int IN_WIDTH   = 14,
    parameter int OUT_WIDTH  = 10,
    parameter int COEF_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_valid,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    output logic                        out_last
);

    logic [2:0] capCnt_q, capCnt_d;
    logic       compBusy_q, compBusy_d;
    logic [2:0] compK_q, compK_d;
    logic       outBusy_q, outBusy_d;
    logic [2:0] outCnt_q, outCnt_d;
    logic       rowDone, lastStep;

    logic signed [IN_WIDTH-1:0]  capBuf_q  [ROW_LEN];
    logic signed [IN_WIDTH-1:0]  compBuf_q [ROW_LEN];
    logic signed [OUT_WIDTH-1:0] outBuf_q  [ROW_LEN];
    logic signed [OUT_WIDTH-1:0] macResult [ROW_LEN];

    always_comb begin
        capCnt_d   = capCnt_q;
        rowDone    = 1'b0;
        compBusy_d = compBusy_q;
        compK_d    = compK_q;
        lastStep   = compBusy_q && (compK_q == 3'd7);
        outBusy_d  = outBusy_q;
        outCnt_d   = outCnt_q;

        if (in_valid) begin
            capCnt_d = capCnt_q + 3'd1;
            rowDone  = (capCnt_q == 3'd7);
        end

        if (compBusy_q) begin
            compK_d = compK_q + 3'd1;
            if (lastStep) begin
                compBusy_d = 1'b0;
            end
        end
        // A new row can only finish on the very edge the previous compute ends
        if (rowDone) begin
            compBusy_d = 1'b1;
            compK_d    = 3'd0;
        end

        if (outBusy_q) begin
            outCnt_d = outCnt_q + 3'd1;
            if (outCnt_q == 3'd7) begin
                outBusy_d = 1'b0;
            end
        end
        if (lastStep) begin
            outBusy_d = 1'b1;
            outCnt_d  = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            capCnt_q   <= 3'd0;
            compBusy_q <= 1'b0;
            compK_q    <= 3'd0;
            outBusy_q  <= 1'b0;
            outCnt_q   <= 3'd0;
        end else begin
            capCnt_q   <= capCnt_d;
            compBusy_q <= compBusy_d;
            compK_q    <= compK_d;
            outBusy_q  <= outBusy_d;
            outCnt_q   <= outCnt_d;
        end
    end

    // X[7] goes straight from in_data into the compute buffer
    always_ff @(posedge clk) begin
        if (in_valid) begin
            capBuf_q[capCnt_q] <= in_data;
        end
        if (rowDone) begin
            for (int i = 0; i < ROW_LEN - 1; i++) begin
                compBuf_q[i] <= capBuf_q[i];
            end
            compBuf_q[ROW_LEN-1] <= in_data;
        end
        if (lastStep) begin
            outBuf_q <= macResult;
        end
    end

    idct_mac8 #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .COEF_WIDTH(COEF_WIDTH)
    ) u_mac8 (
        .clk     (clk),
        .en_i    (compBusy_q),
        .first_i (compK_q == 3'd0),
        .k_i     (compK_q),
        .x_i     (compBuf_q[compK_q]),
        .result_o(macResult)
    );

    assign out_valid = outBusy_q && !rst;
    assign out_last  = out_valid && (outCnt_q == 3'd7);
    assign out_data  = out_valid ? outBuf_q[outCnt_q] : '0;

endmodule

// File: tb/tb_idct_row.sv
// Self-checking bench for idct_row: vector table, random rows against a
// real-arithmetic reference, streaming, gaps, resets and a DCT round trip.
module tb_idct_row;
    import idct_row_pkg::*;

    localparam int IN_W  = 14;
    localparam int OUT_W = 10;
    localparam real PI   = 3.14159265358979;

    typedef int row_t [8];
    typedef struct {
        row_t x;
        row_t y;
    } vec_t;
    typedef struct {
        int value;
        int cycle;
        int tol;
        bit last;
    } expItem_t;

    logic clk = 1'b0;
    logic rst;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_last;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;
    int lastEdge    = 0;
    expItem_t expQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    idct_row #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .COEF_WIDTH(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last)
    );

    task automatic checkOutput(input string name, input int got, input int want, input int tol);
        int diff;
        testsRun++;
        diff = (got > want) ? got - want : want - got;
        if (diff > tol) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, required %0d (tol %0d) at cycle %0d", name, got, want, tol, cyc);
        end
    endtask

    // Reference IDCT built directly from the cosine definition
    function automatic void refRow(input row_t x, output row_t y);
        real    ck, wr;
        longint acc, w, r;
        for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) begin
                ck  = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                wr  = 2048.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * PI / 16.0);
                w   = longint'($floor(wr + 0.5));
                acc = acc + longint'(x[k]) * w;
            end
            r = longint'($floor(real'(acc) / 2048.0 + 0.5));
            if (r > 511) r = 511;
            if (r < -512) r = -512;
            y[n] = int'(r);
        end
    endfunction

    function automatic void fwdDct(input row_t x, output row_t cx);
        real ck, s;
        for (int k = 0; k < 8; k++) begin
            ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            s  = 0.0;
            for (int n = 0; n < 8; n++) begin
                s = s + real'(x[n]) * $cos(real'((2 * n + 1) * k) * PI / 16.0);
            end
            cx[k] = int'($floor(ck / 2.0 * s + 0.5));
        end
    endfunction

    function automatic row_t randRow(input int span);
        row_t r;
        for (int k = 0; k < 8; k++) begin
            r[k] = int'($urandom_range(2 * span)) - span;
        end
        return r;
    endfunction

    task automatic sendSample(input int v);
        dctPort_t p;
        p.data   = IN_W'(v);
        p.valid  = 1'b1;
        in_data  = p.data;
        in_valid = p.valid;
        @(posedge clk);
        #1;
        lastEdge = cyc;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input row_t x, input bit gapped, input row_t want, input int tol);
        expItem_t e;
        for (int k = 0; k < 8; k++) begin
            if (gapped && k > 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            sendSample(x[k]);
        end
        for (int n = 0; n < 8; n++) begin
            e.value = want[n];
            e.cycle = lastEdge + 8 + n;
            e.tol   = tol;
            e.last  = (n == 7);
            expQ.push_back(e);
        end
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (expQ.size() != 0 && guard < 64) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drainTimeout: got %0d pending outputs, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        expQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        expItem_t e;
        if (out_valid) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedOutput: got out_data %0d at cycle %0d, required no output", out_data, cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput("outData", int'(out_data), e.value, e.tol);
                checkOutput("outCycle", cyc, e.cycle, 0);
                checkOutput("outLast", int'(out_last), int'(e.last), 0);
            end
        end else begin
            checkOutput("idleData", int'(out_data), 0, 0);
            checkOutput("idleLast", int'(out_last), 0, 0);
        end
    end

    initial begin
        vec_t vecs[6];
        row_t rx, ry, rows[4], ramp, rampDct;

        vecs[0].x = '{800, 0, 0, 0, 0, 0, 0, 0};
        vecs[0].y = '{283, 283, 283, 283, 283, 283, 283, 283};
        vecs[1].x = '{8191, 0, 0, 0, 0, 0, 0, 0};
        vecs[1].y = '{511, 511, 511, 511, 511, 511, 511, 511};
        vecs[2].x = '{-8192, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].y = '{-512, -512, -512, -512, -512, -512, -512, -512};
        vecs[3].x = '{-800, 0, 0, 0, 0, 0, 0, 0};
        vecs[3].y = '{-283, -283, -283, -283, -283, -283, -283, -283};
        vecs[4].x = '{0, 100, 0, 0, 0, 0, 0, 0};
        vecs[4].y = '{49, 42, 28, 10, -10, -28, -42, -49};
        vecs[5].x = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5].y = '{0, 0, 0, 0, 0, 0, 0, 0};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetValid", int'(out_valid), 0, 0);
        checkOutput("resetLast", int'(out_last), 0, 0);
        checkOutput("resetData", int'(out_data), 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].x, 1'b0, vecs[i].y, 0);
            waitDrain();
        end

        for (int i = 0; i < 6; i++) begin
            rx = randRow((i < 4) ? 2500 : 8000);
            refRow(rx, ry);
            applyStimulus(rx, 1'b0, ry, 0);
            waitDrain();
        end

        for (int r = 0; r < 4; r++) rows[r] = randRow(3000);
        for (int r = 0; r < 4; r++) begin
            refRow(rows[r], ry);
            applyStimulus(rows[r], 1'b0, ry, 0);
        end
        waitDrain();

        rx = randRow(3000);
        refRow(rx, ry);
        applyStimulus(rx, 1'b0, ry, 0);
        waitDrain();
        applyStimulus(rx, 1'b1, ry, 0);
        waitDrain();

        for (int k = 0; k < 5; k++) sendSample(1000 + k);
        in_valid = 1'b1;
        in_data  = IN_W'(123);
        pulseReset();
        in_valid = 1'b0;
        applyStimulus(vecs[0].x, 1'b0, vecs[0].y, 0);
        waitDrain();
        repeat (20) @(posedge clk);
        #1;

        rx = randRow(3000);
        refRow(rx, ry);
        applyStimulus(rx, 1'b0, ry, 0);
        repeat (3) @(posedge clk);
        #1;
        pulseReset();
        repeat (20) @(posedge clk);
        #1;
        applyStimulus(rx, 1'b0, ry, 0);
        repeat (10) @(posedge clk);
        #1;
        pulseReset();
        repeat (20) @(posedge clk);
        #1;

        ramp = '{0, 70, 10, 60, 20, 50, 30, 40};
        fwdDct(ramp, rampDct);
        applyStimulus(rampDct, 1'b0, ramp, 2);
        waitDrain();
        repeat (20) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/idct_row.md
IDCT_ROW -- requirements
Module: idct_row

Interface
REQ-001 Parameter IN_WIDTH, default 14, signed width of the incoming DCT coefficients.
REQ-002 Parameter OUT_WIDTH, default 10, signed width of the reconstructed samples.
REQ-003 Parameter COEF_WIDTH, default 12, signed cosine coefficient width with scale 2^11.
REQ-004 Port clk  input  1  sole clock, rising-edge active.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_data  input  IN_WIDTH  signed coefficient X[k]; a row arrives in order k=0..7.
REQ-007 Port in_valid  input  1  in_data is sampled on every rising edge where this is high.
REQ-008 Port out_data  output  OUT_WIDTH  signed reconstructed sample x[n]; a row leaves in order n=0..7.
REQ-009 Port out_valid  output  1  out_data is meaningful this cycle.
REQ-010 Port out_last  output  1  high together with out_valid on x[7] only.

Function
REQ-011 The block SHALL compute x[n] = sum over k of C(k)/2 * X[k] * cos((2n+1)k*pi/16), with C(0)=1/sqrt(2) and C(k>0)=1.
REQ-012 The block SHALL use coefficients W[n][k] = round(2048*C(k)/2*cos((2n+1)k*pi/16)) held in a constant table; for example W[*][0]=724 and W[0][1]=1004.
REQ-013 The block SHALL use signed accumulators of IN_WIDTH+COEF_WIDTH+3 bits, so that no intermediate overflow occurs.
REQ-014 Each result SHALL be (acc+1024)>>>11 (arithmetic shift), then saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-015 Capture stage: a 3-bit counter SHALL count accepted samples; the sample accepted at count 7 completes the row, and the counter wraps to 0.
REQ-016 Gaps (in_valid low) SHALL pause capture without loss; a row may span any number of cycles.
REQ-017 Compute stage: on row completion, the 8 captured values SHALL be copied to a compute buffer.
REQ-018 The compute stage SHALL then run for exactly 8 cycles; in cycle k, all 8 accumulators add X[k]*W[n][k] in parallel.
REQ-019 Output stage: after compute, the 8 results SHALL load into an output register and stream on 8 consecutive cycles.
REQ-020 Latency: x[0] SHALL be presented in the 9th cycle after the edge that samples X[7], and x[7] in the 16th.
REQ-021 Capture, compute and output SHALL run concurrently on different rows, sustaining 1 sample/cycle with back-to-back rows and no gaps on out_valid.
REQ-022 No backpressure exists; the input rate never exceeds 1/cycle, so no stage overruns; there is no ready signal.
REQ-023 A row completed while the previous row is still computing is impossible (8-cycle minimum per row), and the design SHALL rely on this property.
REQ-024 When out_valid is low, out_data SHALL be 0.

Reset
REQ-025 When rst is high at an edge, the capture counter, compute cycle counter, output counter and all stage-busy flags SHALL clear.
REQ-026 During reset, out_data=0, out_valid=0 and out_last=0.
REQ-027 A reset mid-row or mid-compute/output SHALL discard every partial row, with no output emitted for it.
REQ-028 in_valid SHALL be ignored while rst is high; the first sample after deassertion is X[0] of a new row.
REQ-029 Data buffers SHALL need no reset.

Structure
REQ-030 The shared package SHALL hold the dctPort_t struct (data, valid), the 8x8 coefficient table W, and the constants ROW_LEN=8 and COEF_SHIFT=11.
REQ-031 One sub-module, idct_mac8, SHALL hold the 8 parallel multiply-accumulators, rounding and saturation.
REQ-032 idct_row SHALL hold the capture, sequencing and output serialisation.

Verification
REQ-033 Scenario, DC row: X=[800,0,0,0,0,0,0,0] -> eight outputs of 283, out_last on the 8th, x[0] 9 cycles after X[7].
REQ-034 Scenario, saturation: X=[8191,0,...] -> all 511; X=[-8192,0,...] -> all -512.
REQ-035 Scenario, streaming: 4 rows on 32 consecutive valid cycles -> 32 consecutive out_valid cycles, each row matching a float model within +/-1 LSB.
REQ-036 Scenario, gapped input: the same row with in_valid toggling every other cycle -> output identical to the ungapped case, timed from X[7].
REQ-037 Scenario, reset mid-row: 5 samples, rst high 1 cycle, then a full DC row of 800 -> exactly one output row of 283s.
REQ-038 Scenario, round trip: ramp row 0,70,10,60,20,50,30,40 through Dct, then idct_row -> the original values within +/-2 LSB.
